// File: rtl/flit_arbiter_n_if.sv
// Flit type, checksum helper and the handshake bundle of the flit arbiter.
// The checksum byte of a flit is the XOR of its three payload bytes.

package types;

    typedef struct packed {
        logic [7:0]  checksum;
        logic [23:0] payload;
    } flit_t;

    // Returns the flit with its checksum field recomputed from the payload.
    function automatic flit_t calculate_checksum_comb(input flit_t f);
        flit_t r;
        r          = f;
        r.checksum = f.payload[23:16] ^ f.payload[15:8] ^ f.payload[7:0];
        return r;
    endfunction

endpackage

interface flit_arbiter_n_if #(
    parameter int NUM_NORMAL = 4
);
    localparam int SRC_W = $clog2(NUM_NORMAL) + 1;

    types::flit_t                    in_system_flit;
    logic                            in_system_flit_valid;
    logic                            in_system_flit_ready;

    types::flit_t [NUM_NORMAL-1:0]   in_normal_flit;
    logic [NUM_NORMAL-1:0]           in_normal_flit_valid;
    logic [NUM_NORMAL-1:0]           in_normal_last;
    logic [NUM_NORMAL-1:0]           in_normal_flit_ready;

    types::flit_t                    out_flit;
    logic                            out_flit_valid;
    logic                            out_flit_ready;
    logic [SRC_W-1:0]                out_src;

    // Traffic side: drives sources and the downstream ready.
    modport master (
        output in_system_flit, in_system_flit_valid,
        input  in_system_flit_ready,
        output in_normal_flit, in_normal_flit_valid, in_normal_last,
        input  in_normal_flit_ready,
        input  out_flit, out_flit_valid, out_src,
        output out_flit_ready
    );

    // Arbiter side.
    modport slave (
        input  in_system_flit, in_system_flit_valid,
        output in_system_flit_ready,
        input  in_normal_flit, in_normal_flit_valid, in_normal_last,
        output in_normal_flit_ready,
        output out_flit, out_flit_valid, out_src,
        input  out_flit_ready
    );

endinterface

// File: rtl/flit_arbiter_n.sv
// Packet-aware flit arbiter: one system channel with bounded priority over
// NUM_NORMAL round-robin normal channels. A multi-flit normal packet locks
// the output until its last flit, so packets are never interleaved.
// Output is a single register stage carrying the checksummed flit.

module flit_arbiter_n #(
    parameter int NUM_NORMAL   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            nocclk,
    input  logic            rst,
    flit_arbiter_n_if.slave bus
);

    localparam int IDX_W = (NUM_NORMAL > 1) ? $clog2(NUM_NORMAL) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int SRC_W = $clog2(NUM_NORMAL) + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   lock_ch_reg, lock_ch_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;

    types::flit_t       out_flit_reg;
    logic               out_valid_reg;
    logic [SRC_W-1:0]   out_src_reg;

    logic               load_en;
    logic               any_normal;
    logic               sel_sys;
    logic               sel_norm;
    logic [IDX_W-1:0]   sel_ch;
    logic               sys_accept;
    logic               norm_accept;
    types::flit_t       sel_flit;
    logic [SRC_W-1:0]   sel_src;

    logic [IDX_W-1:0]   cand_ch [NUM_NORMAL];
    logic [NUM_NORMAL-1:0] cand_valid;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_ch;

    assign load_en    = !out_valid_reg || bus.out_flit_ready;
    assign any_normal = |bus.in_normal_flit_valid;

    // Candidate list rotated so entry 0 is the channel at rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_NORMAL; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_ch[gi] = (sum >= (IDX_W+1)'(NUM_NORMAL))
                               ? IDX_W'(sum - (IDX_W+1)'(NUM_NORMAL))
                               : sum[IDX_W-1:0];
            assign cand_valid[gi] = bus.in_normal_flit_valid[cand_ch[gi]];
        end
    endgenerate

    // First valid candidate at or after rr_ptr (lowest rotated index wins).
    always_comb begin
        rr_found = |cand_valid;
        rr_ch    = cand_ch[0];
        for (int i = NUM_NORMAL - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                rr_ch = cand_ch[i];
            end
        end
    end

    // Source selection: a lock pins the locked channel; otherwise system
    // wins unless it has already starved waiting normals STARVE_LIMIT times.
    always_comb begin
        sel_sys  = 1'b0;
        sel_norm = 1'b0;
        sel_ch   = rr_ch;
        if (state_reg == LOCKED) begin
            sel_ch   = lock_ch_reg;
            sel_norm = bus.in_normal_flit_valid[lock_ch_reg];
        end else if (bus.in_system_flit_valid &&
                     ((starve_cnt_reg < CNT_W'(STARVE_LIMIT)) || !any_normal)) begin
            sel_sys = 1'b1;
        end else begin
            sel_norm = rr_found;
        end
    end

    assign sys_accept  = sel_sys  && load_en && !rst;
    assign norm_accept = sel_norm && load_en && !rst;
    assign sel_flit    = sel_sys ? bus.in_system_flit : bus.in_normal_flit[sel_ch];
    assign sel_src     = sel_sys ? SRC_W'(NUM_NORMAL) : SRC_W'(sel_ch);

    assign bus.in_system_flit_ready = sys_accept;
    generate
        for (genvar gi = 0; gi < NUM_NORMAL; gi++) begin : g_ready
            assign bus.in_normal_flit_ready[gi] = norm_accept && (sel_ch == IDX_W'(gi));
        end
    endgenerate

    // Next-state: packet lock, round-robin pointer and starvation counter.
    always_comb begin
        state_next      = state_reg;
        lock_ch_next    = lock_ch_reg;
        rr_ptr_next     = rr_ptr_reg;
        starve_cnt_next = starve_cnt_reg;
        if (norm_accept) begin
            if (bus.in_normal_last[sel_ch]) begin
                state_next  = IDLE;
                rr_ptr_next = (sel_ch == IDX_W'(NUM_NORMAL - 1)) ? '0 : sel_ch + 1'b1;
            end else begin
                state_next   = LOCKED;
                lock_ch_next = sel_ch;
            end
        end
        if (norm_accept || !any_normal) begin
            starve_cnt_next = '0;
        end else if (sys_accept && (starve_cnt_reg < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    // Arbitration state register.
    always_ff @(posedge nocclk) begin
        if (rst) begin
            state_reg      <= IDLE;
            lock_ch_reg    <= '0;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            lock_ch_reg    <= lock_ch_next;
            rr_ptr_reg     <= rr_ptr_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Output register: loads on acceptance, empties on drain, holds on stall.
    always_ff @(posedge nocclk) begin
        if (rst) begin
            out_flit_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_src_reg   <= '0;
        end else if (load_en) begin
            if (sys_accept || norm_accept) begin
                out_flit_reg  <= types::calculate_checksum_comb(sel_flit);
                out_src_reg   <= sel_src;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_flit       = out_flit_reg;
    assign bus.out_flit_valid = out_valid_reg;
    assign bus.out_src        = out_src_reg;

endmodule

// File: tb/tb_flit_arbiter_n.sv
// Bench for flit_arbiter_n (4 normal channels, starvation limit 2):
// directed scenarios against fixed expectations, then a randomized run
// against a rule-level reference model.

module tb_flit_arbiter_n;

    localparam int NN = 4;
    localparam int SL = 2;

    logic nocclk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    flit_arbiter_n_if #(.NUM_NORMAL(NN)) bus ();

    flit_arbiter_n #(
        .NUM_NORMAL   (NN),
        .STARVE_LIMIT (SL)
    ) dut (
        .nocclk (nocclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    // Reference model state.
    int           m_lock;
    int           m_rr;
    int           m_starve;
    bit           m_ov;
    types::flit_t m_of;
    int           m_os;

    function automatic types::flit_t ref_chk(input types::flit_t f);
        types::flit_t r;
        r.payload  = f.payload;
        r.checksum = f.payload[7:0] ^ f.payload[15:8] ^ f.payload[23:16];
        return r;
    endfunction

    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_system_flit       = '0;
        bus.in_system_flit_valid = 1'b0;
        bus.in_normal_flit       = '0;
        bus.in_normal_flit_valid = '0;
        bus.in_normal_last       = '0;
        bus.out_flit_ready       = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_system_flit_valid = 1'b1;
        bus.in_normal_flit_valid = 4'hF;
        bus.in_normal_last       = 4'hF;
        #1;
        checks++;
        if (bus.in_system_flit_ready !== 1'b0) begin
            errors++; $display("FAIL reset_sys_ready: got %b expected 0", bus.in_system_flit_ready);
        end
        checks++;
        if (bus.in_normal_flit_ready !== 4'b0) begin
            errors++; $display("FAIL reset_normal_ready: got %b expected 0000", bus.in_normal_flit_ready);
        end
        tick();
        checks++;
        if (bus.out_flit_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_flit_valid);
        end
        checks++;
        if (bus.out_flit !== 32'h0) begin
            errors++; $display("FAIL reset_out_flit: got %h expected 0", bus.out_flit);
        end
        checks++;
        if (bus.out_src !== 3'd0) begin
            errors++; $display("FAIL reset_out_src: got %0d expected 0", bus.out_src);
        end
        $display("txn reset: out_valid=%b out_src=%0d", bus.out_flit_valid, bus.out_src);
        set_idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        types::flit_t fl [NN];
        int           exp_ch;
        do_reset();
        for (int k = 0; k < NN; k++) begin
            fl[k] = types::flit_t'($urandom);
            bus.in_normal_flit[k] = fl[k];
        end
        bus.in_normal_flit_valid = 4'hF;
        bus.in_normal_last       = 4'hF;
        for (int c = 0; c < 5; c++) begin
            exp_ch = c % NN;
            #1;
            checks++;
            if (bus.in_normal_flit_ready !== 4'(1 << exp_ch)) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, bus.in_normal_flit_ready, 4'(1 << exp_ch));
            end
            tick();
            checks++;
            if (bus.out_flit_valid !== 1'b1 || bus.out_src !== 3'(exp_ch)) begin
                errors++; $display("FAIL rr_src[%0d]: got valid=%b src=%0d expected valid=1 src=%0d", c, bus.out_flit_valid, bus.out_src, exp_ch);
            end
            checks++;
            if (bus.out_flit !== ref_chk(fl[exp_ch])) begin
                errors++; $display("FAIL rr_flit[%0d]: got %h expected %h", c, bus.out_flit, ref_chk(fl[exp_ch]));
            end
            $display("txn rr: src=%0d flit=%h", bus.out_src, bus.out_flit);
        end
        set_idle();
    endtask

    task automatic test_system_priority();
        types::flit_t sf, nf;
        do_reset();
        sf = types::flit_t'($urandom);
        nf = types::flit_t'($urandom);
        bus.in_system_flit       = sf;
        bus.in_system_flit_valid = 1'b1;
        bus.in_normal_flit[2]    = nf;
        bus.in_normal_flit_valid = 4'b0100;
        bus.in_normal_last       = 4'b0100;
        #1;
        checks++;
        if (bus.in_system_flit_ready !== 1'b1 || bus.in_normal_flit_ready !== 4'b0) begin
            errors++; $display("FAIL prio_ready: got sys=%b normal=%b expected sys=1 normal=0000", bus.in_system_flit_ready, bus.in_normal_flit_ready);
        end
        tick();
        checks++;
        if (bus.out_src !== 3'd4 || bus.out_flit !== ref_chk(sf)) begin
            errors++; $display("FAIL prio_sys_out: got src=%0d flit=%h expected src=4 flit=%h", bus.out_src, bus.out_flit, ref_chk(sf));
        end
        $display("txn prio: src=%0d flit=%h", bus.out_src, bus.out_flit);
        bus.in_system_flit_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_normal_flit_ready !== 4'b0100) begin
            errors++; $display("FAIL prio_ch2_ready: got %b expected 0100", bus.in_normal_flit_ready);
        end
        tick();
        checks++;
        if (bus.out_src !== 3'd2 || bus.out_flit !== ref_chk(nf)) begin
            errors++; $display("FAIL prio_ch2_out: got src=%0d flit=%h expected src=2 flit=%h", bus.out_src, bus.out_flit, ref_chk(nf));
        end
        $display("txn prio: src=%0d flit=%h", bus.out_src, bus.out_flit);
        set_idle();
        tick();
        checks++;
        if (bus.out_flit_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got valid=%b expected 0", bus.out_flit_valid);
        end
    endtask

    task automatic test_starvation();
        int exp_src [6] = '{4, 4, 1, 4, 4, 1};
        do_reset();
        bus.in_system_flit       = types::flit_t'($urandom);
        bus.in_system_flit_valid = 1'b1;
        bus.in_normal_flit[1]    = types::flit_t'($urandom);
        bus.in_normal_flit_valid = 4'b0010;
        bus.in_normal_last       = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.out_flit_valid !== 1'b1 || bus.out_src !== 3'(exp_src[c])) begin
                errors++; $display("FAIL starve_seq[%0d]: got valid=%b src=%0d expected src=%0d", c, bus.out_flit_valid, bus.out_src, exp_src[c]);
            end
            $display("txn starve: src=%0d", bus.out_src);
        end
        set_idle();
    endtask

    task automatic test_packet_lock();
        types::flit_t p [3];
        int           exp_src [4] = '{0, 0, 0, 4};
        do_reset();
        for (int i = 0; i < 3; i++) p[i] = types::flit_t'($urandom);
        bus.in_normal_flit[0]    = p[0];
        bus.in_normal_flit_valid = 4'b0001;
        bus.in_normal_last       = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.in_system_flit       = types::flit_t'($urandom);
                bus.in_system_flit_valid = 1'b1;
                bus.in_normal_flit[1]    = types::flit_t'($urandom);
                bus.in_normal_flit_valid = 4'b0011;
                bus.in_normal_last       = 4'b0010;
            end
            if (c >= 1 && c <= 2) begin
                bus.in_normal_flit[0] = p[c];
                bus.in_normal_last[0] = (c == 2);
                #1;
                checks++;
                if (bus.in_system_flit_ready !== 1'b0 || bus.in_normal_flit_ready !== 4'b0001) begin
                    errors++; $display("FAIL lock_ready[%0d]: got sys=%b normal=%b expected sys=0 normal=0001", c, bus.in_system_flit_ready, bus.in_normal_flit_ready);
                end
            end
            if (c == 3) bus.in_normal_flit_valid[0] = 1'b0;
            tick();
            checks++;
            if (bus.out_flit_valid !== 1'b1 || bus.out_src !== 3'(exp_src[c])) begin
                errors++; $display("FAIL lock_seq[%0d]: got valid=%b src=%0d expected src=%0d", c, bus.out_flit_valid, bus.out_src, exp_src[c]);
            end
            if (c < 3) begin
                checks++;
                if (bus.out_flit !== ref_chk(p[c])) begin
                    errors++; $display("FAIL lock_flit[%0d]: got %h expected %h", c, bus.out_flit, ref_chk(p[c]));
                end
            end
            $display("txn lock: src=%0d flit=%h", bus.out_src, bus.out_flit);
        end
        set_idle();
    endtask

    task automatic test_backpressure();
        types::flit_t a, sf;
        do_reset();
        a  = types::flit_t'($urandom);
        sf = types::flit_t'($urandom);
        bus.in_normal_flit[3]    = a;
        bus.in_normal_flit_valid = 4'b1000;
        bus.in_normal_last       = 4'b1000;
        tick();
        bus.out_flit_ready       = 1'b0;
        bus.in_normal_flit_valid = 4'b0001;
        bus.in_normal_last       = 4'b0001;
        bus.in_system_flit       = sf;
        bus.in_system_flit_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.in_system_flit_ready !== 1'b0 || bus.in_normal_flit_ready !== 4'b0) begin
                errors++; $display("FAIL stall_ready[%0d]: got sys=%b normal=%b expected all 0", c, bus.in_system_flit_ready, bus.in_normal_flit_ready);
            end
            tick();
            checks++;
            if (bus.out_flit_valid !== 1'b1 || bus.out_src !== 3'd3 || bus.out_flit !== ref_chk(a)) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b src=%0d flit=%h expected valid=1 src=3 flit=%h", c, bus.out_flit_valid, bus.out_src, bus.out_flit, ref_chk(a));
            end
            $display("txn stall: held src=%0d flit=%h", bus.out_src, bus.out_flit);
        end
        bus.out_flit_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_system_flit_ready !== 1'b1) begin
            errors++; $display("FAIL resume_ready: got %b expected 1", bus.in_system_flit_ready);
        end
        tick();
        checks++;
        if (bus.out_src !== 3'd4 || bus.out_flit !== ref_chk(sf)) begin
            errors++; $display("FAIL resume_out: got src=%0d flit=%h expected src=4 flit=%h", bus.out_src, bus.out_flit, ref_chk(sf));
        end
        $display("txn resume: src=%0d flit=%h", bus.out_src, bus.out_flit);
        set_idle();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.in_normal_flit[0]    = types::flit_t'($urandom);
        bus.in_normal_flit_valid = 4'b0001;
        bus.in_normal_last       = 4'b0000;
        tick();
        tick();
        checks++;
        if (bus.out_src !== 3'd0 || bus.out_flit_valid !== 1'b1) begin
            errors++; $display("FAIL midpkt_pre: got valid=%b src=%0d expected valid=1 src=0", bus.out_flit_valid, bus.out_src);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.out_flit_valid !== 1'b0) begin
            errors++; $display("FAIL midpkt_rst_valid: got %b expected 0", bus.out_flit_valid);
        end
        rst = 1'b0;
        bus.in_normal_flit_valid = 4'b0010;
        bus.in_normal_last       = 4'b0010;
        bus.in_normal_flit[1]    = types::flit_t'($urandom);
        #1;
        checks++;
        if (bus.in_normal_flit_ready !== 4'b0010) begin
            errors++; $display("FAIL midpkt_ch1_ready: got %b expected 0010", bus.in_normal_flit_ready);
        end
        tick();
        checks++;
        if (bus.out_flit_valid !== 1'b1 || bus.out_src !== 3'd1) begin
            errors++; $display("FAIL midpkt_ch1_out: got valid=%b src=%0d expected valid=1 src=1", bus.out_flit_valid, bus.out_src);
        end
        $display("txn midpkt: src=%0d", bus.out_src);
        set_idle();
    endtask

    task automatic test_random();
        types::flit_t        sf;
        types::flit_t        nf [NN];
        logic [NN-1:0]       nv, nl;
        bit                  sv, ordy, load;
        int                  g;
        do_reset();
        m_lock = -1; m_rr = 0; m_starve = 0; m_ov = 1'b0; m_of = '0; m_os = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst  = ($urandom_range(0, 79) == 0);
            sv   = ($urandom_range(0, 1) == 1);
            sf   = types::flit_t'($urandom);
            nv   = 4'($urandom);
            nl   = 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NN; k++) begin
                nf[k] = types::flit_t'($urandom);
                bus.in_normal_flit[k] = nf[k];
            end
            bus.in_system_flit       = sf;
            bus.in_system_flit_valid = sv;
            bus.in_normal_flit_valid = nv;
            bus.in_normal_last       = nl;
            bus.out_flit_ready       = ordy;

            // Grant decided from the arbitration rules.
            load = !m_ov || ordy;
            g    = -1;
            if (!rst && load) begin
                if (m_lock >= 0) begin
                    if (nv[m_lock]) g = m_lock;
                end else if (sv && (m_starve < SL || nv == 0)) begin
                    g = NN;
                end else begin
                    for (int i = 0; i < NN; i++) begin
                        int k;
                        k = (m_rr + i) % NN;
                        if (g < 0 && nv[k]) g = k;
                    end
                end
            end
            #1;
            checks++;
            if (bus.in_system_flit_ready !== (g == NN) ||
                bus.in_normal_flit_ready !== ((g >= 0 && g < NN) ? 4'(1 << g) : 4'b0)) begin
                errors++; $display("FAIL rand_ready[%0d]: got sys=%b normal=%b expected grant=%0d", cyc, bus.in_system_flit_ready, bus.in_normal_flit_ready, g);
            end

            @(posedge nocclk);
            if (rst) begin
                m_lock = -1; m_rr = 0; m_starve = 0; m_ov = 1'b0; m_of = '0; m_os = 0;
            end else begin
                if (load) begin
                    if (g >= 0) begin
                        m_ov = 1'b1;
                        m_of = ref_chk((g == NN) ? sf : nf[g]);
                        m_os = g;
                    end else begin
                        m_ov = 1'b0;
                    end
                end
                if ((g >= 0 && g < NN) || nv == 0) m_starve = 0;
                else if (g == NN && m_starve < SL) m_starve++;
                if (g >= 0 && g < NN) begin
                    if (nl[g]) begin
                        m_lock = -1;
                        m_rr   = (g + 1) % NN;
                    end else begin
                        m_lock = g;
                    end
                end
            end
            #1;
            checks++;
            if (bus.out_flit_valid !== m_ov) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, bus.out_flit_valid, m_ov);
            end else if (m_ov) begin
                checks++;
                if (bus.out_src !== 3'(m_os) || bus.out_flit !== m_of) begin
                    errors++; $display("FAIL rand_out[%0d]: got src=%0d flit=%h expected src=%0d flit=%h", cyc, bus.out_src, bus.out_flit, m_os, m_of);
                end
                if (g >= 0) $display("txn rand[%0d]: src=%0d flit=%h", cyc, bus.out_src, bus.out_flit);
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_round_robin();
        test_system_priority();
        test_starvation();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flit_arbiter_n.md
FLIT_ARBITER_N -- requirements
Module: flit_arbiter_n

Interface
REQ-001 Parameter NUM_NORMAL, default 4: number of normal input channels, legal range 1..16.
REQ-002 Parameter STARVE_LIMIT, default 8: maximum consecutive system grants while any normal channel is waiting, legal values >=1.
REQ-003 nocclk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_system_flit  input  types::flit_t  system-channel flit.
REQ-006 in_system_flit_valid  input  1  system flit present.
REQ-007 in_system_flit_ready  output  1  system flit accepted this cycle when valid and ready are both high.
REQ-008 in_normal_flit  input  NUM_NORMAL x types::flit_t  normal-channel flits.
REQ-009 in_normal_flit_valid  input  NUM_NORMAL  per-channel valid.
REQ-010 in_normal_last  input  NUM_NORMAL  per-channel last-flit-of-packet marker.
REQ-011 in_normal_flit_ready  output  NUM_NORMAL  per-channel accept.
REQ-012 out_flit  output  types::flit_t  registered flit with checksum applied.
REQ-013 out_flit_valid  output  1  out_flit holds a flit.
REQ-014 out_flit_ready  input  1  downstream accepts.
REQ-015 out_src  output  $clog2(NUM_NORMAL)+1  source of out_flit: value NUM_NORMAL = system; 0..NUM_NORMAL-1 = normal channel index.

Function
REQ-016 load_en = !out_flit_valid || out_flit_ready; a source is accepted only when load_en=1.
REQ-017 Each cycle at most one input ready bit is high, and it goes only to the selected source whose valid is high; the ready bits are combinational from the current state and the valid inputs.
REQ-018 The selected flit passes through calculate_checksum_comb before registration, giving a latency of exactly 1 cycle from acceptance to out_flit_valid=1.
REQ-019 While out_flit_valid=1 and out_flit_ready=0, out_flit, out_src and out_flit_valid stay stable.
REQ-020 When out_flit_ready=1 and no source is accepted, out_flit_valid goes to 0 next cycle.
REQ-021 State machine states:
- IDLE: no packet lock.
- LOCKED: holds lock_ch.
REQ-022 IDLE -> LOCKED(k) when a normal flit from channel k is accepted with in_normal_last[k]=0.
REQ-023 LOCKED(k) -> IDLE when a channel-k flit is accepted with in_normal_last[k]=1.
REQ-024 In LOCKED(k), only channel k is selectable; system flits and other channels wait (no interleaving).
REQ-025 Selection in IDLE:
- Choose system if in_system_flit_valid=1 and (starve_cnt < STARVE_LIMIT or no normal valid).
- Otherwise choose the first valid normal channel searching from rr_ptr upward, wrapping modulo NUM_NORMAL.
REQ-026 A system flit is always single-flit and never causes LOCKED.
REQ-027 rr_ptr = (k+1) mod NUM_NORMAL after a channel-k flit is accepted with last=1.
REQ-028 rr_ptr is unchanged by system grants and by non-last flits.
REQ-029 starve_cnt rules:
- +1 on a system acceptance while any normal valid is high, saturating at STARVE_LIMIT.
- Cleared to 0 on any normal acceptance, or in any cycle where no normal valid is high.
REQ-030 An acceptance and an output drain in the same cycle are legal (back-to-back throughput of 1 flit/cycle).

Reset
REQ-031 While rst=1 at the clock edge:
- out_flit_valid=0, out_flit=0, out_src=0.
- State=IDLE, lock cleared, rr_ptr=0, starve_cnt=0.
REQ-032 While rst=1, all ready outputs are 0.
REQ-033 Reset mid-packet abandons the lock; the next cycle arbitrates from IDLE with no memory of the partial packet.

Verification
REQ-034 NUM_NORMAL=4; normals 0..3 valid continuously, single-flit (last=1), ready=1 -> grant order 0,1,2,3,0; out_src matches that order, 1 flit/cycle, each output one cycle after acceptance.
REQ-035 System and normal 2 both valid, starve_cnt=0 -> system granted first, out_src=4; normal 2 granted next cycle once system valid drops.
REQ-036 STARVE_LIMIT=2; system valid continuously, normal 1 valid -> grants system, system, ch1, system, system, ch1.
REQ-037 Channel 0 sends a 3-flit packet (last on flit 3) while system and channel 1 are valid -> outputs ch0,ch0,ch0 contiguous, then system.
REQ-038 out_flit_ready=0 for 3 cycles with out_flit_valid=1 -> out_flit stable, all ready outputs 0, no flit lost; drain resumes on ready=1.
REQ-039 rst=1 after flit 2 of a channel-0 packet -> next cycle out_flit_valid=0, IDLE; channel 1 then wins arbitration immediately.
